// File: rtl/tff_count_ctrl_pkg.sv
// tff_count_ctrl_pkg: state encoding and width bounds shared by the TFF sequencer
package tff_count_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 16;
endpackage

// File: rtl/tff_count_ctrl_toggle_mask.sv
// toggle_mask: T-input mask that moves a TFF bank by +1 (up) or -1 (down)
module toggle_mask #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] mask
);
  logic [WIDTH-1:0] hit;
  // a stage toggles when every lower stage sits at 1 (up) or at 0 (down)
  assign hit = q ~^ {WIDTH{up}};
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) mask[i] = &(hit | ~((WIDTH'(1) << i) - WIDTH'(1)));
  end
endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: one-shot / free-run up/down sequencer driving an external TFF bank
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             mode,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             tff_reset,
  output logic             busy,
  output logic             done,
  output logic             tick
);
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("tff_count_ctrl: WIDTH %0d outside 1..16", WIDTH);
  end
  state_t           state, state_nx;
  logic [WIDTH-1:0] limit_r, init, term, step;
  logic             up_r, mode_r;
  toggle_mask #(.WIDTH(WIDTH)) u_mask (.q(q), .up(up_r), .mask(step));
  assign init      = up_r ? '0 : limit_r;
  assign term      = up_r ? limit_r : '0;
  assign tff_reset = reset;
  assign busy      = state == LOAD || state == RUN;
  assign done      = state == DONE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      limit_r <= '0;
      up_r    <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && !stop) begin
        limit_r <= limit;
        up_r    <= up;
        mode_r  <= mode;
      end
    end
  end
  always_comb begin
    state_nx = state;
    t        = '0;
    tick     = 1'b0;
    case (state)
      IDLE: state_nx = start ? LOAD : IDLE;
      LOAD: begin
        t        = q ^ init;
        state_nx = RUN;
      end
      RUN: if (en) begin
        tick     = q == term;
        t        = !tick ? step : mode_r ? q ^ init : '0;
        state_nx = tick && !mode_r ? DONE : RUN;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort and reset freeze the bank and override any terminal-count action
    if (stop || reset) begin
      state_nx = IDLE;
      t        = '0;
      tick     = 1'b0;
    end
  end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: directed bench with a TFF bank and an arithmetic reference model
module tb_tff_count_ctrl;
  logic       clock = 1'b0;
  logic       reset, start, stop, up, mode, en;
  logic [3:0] limit, q, t;
  logic       tff_reset, busy, done, tick;
  int         nvec = 0, nerr = 0, ticks;
  bit         chk = 1'b0;
  int         ph = 0;
  logic [3:0] mv = '0, ml = '0;
  bit         mu = 1'b0, mm = 1'b0;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .up(up), .mode(mode),
    .en(en), .limit(limit), .q(q), .t(t), .tff_reset(tff_reset), .busy(busy),
    .done(done), .tick(tick)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) q <= tff_reset ? '0 : q ^ t;

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // model: ph 0 idle, 1 load, 2 run, 3 done; mv is the value the bank must hold
  always @(negedge clock) if (chk) begin
    logic [3:0] init, term, nq;
    bit         etick;
    int         nph;
    init  = mu ? 4'd0 : ml;
    term  = mu ? ml : 4'd0;
    nq    = mv;
    nph   = ph;
    etick = 1'b0;
    if (reset) begin
      nph = 0;
      nq  = '0;
    end else if (stop) nph = 0;
    else case (ph)
      0: if (start) begin
        nph = 1;
        ml  = limit;
        mu  = up;
        mm  = mode;
      end
      1: begin
        nq  = init;
        nph = 2;
      end
      2: if (en) begin
        if (mv == term) begin
          etick = 1'b1;
          if (mm) nq = init;
          else nph = 3;
        end else nq = mu ? mv + 4'd1 : mv - 4'd1;
      end
      default: nph = 0;
    endcase
    lit("m_q", q, mv);
    lit("m_t", t, reset ? 4'd0 : mv ^ nq);
    lit("m_tick", tick, etick);
    lit("m_busy", busy, ph == 1 || ph == 2);
    lit("m_done", done, ph == 3);
    lit("m_tff_reset", tff_reset, reset);
    mv = nq;
    ph = nph;
  end

  initial begin
    reset = 1; start = 0; stop = 0; up = 0; mode = 0; en = 0; limit = 0;
    adv(1);
    chk = 1'b1;
    adv(1);
    reset = 0;
    #1;
    lit("rst_q", q, 0); lit("rst_busy", busy, 0); lit("rst_done", done, 0);
    lit("rst_t", t, 0); lit("rst_tick", tick, 0);
    // one-shot up, limit 3
    start = 1; up = 1; mode = 0; limit = 3; en = 1;
    adv(1); start = 0; #1;
    lit("a_load_busy", busy, 1);
    adv(1); lit("a_q0", q, 0);
    adv(1); lit("a_q1", q, 1);
    adv(1); lit("a_q2", q, 2);
    adv(1); lit("a_q3", q, 3); lit("a_tick", tick, 1);
    adv(1); lit("a_done", done, 1); lit("a_hold", q, 3); lit("a_done_tick", tick, 0);
    adv(1); lit("a_done_off", done, 0); lit("a_idle", busy, 0); lit("a_q_end", q, 3);
    // free-run down, limit 5; limit/up change and start mid-count are ignored
    start = 1; up = 0; mode = 1; limit = 5;
    adv(1); start = 0; limit = 9; up = 1; #1;
    lit("b_load_t", t, 4'h6);
    adv(1); lit("b_first", q, 5);
    ticks = 0;
    for (int i = 0; i < 18; i++) begin
      start = (i == 7);
      #1;
      if (tick) ticks++;
      lit("b_q", q, 5 - (i % 6));
      lit("b_busy", busy, 1);
      adv(1);
    end
    start = 0;
    lit("b_ticks", ticks, 3);
    stop = 1; adv(1); stop = 0; #1;
    lit("b_stop_busy", busy, 0); lit("b_stop_q", q, 5);
    // one-shot up, limit 1, stop on the terminal cycle
    start = 1; up = 1; mode = 0; limit = 1;
    adv(1); start = 0; #1;
    lit("c_load_t", t, 4'h5);
    adv(1); lit("c_q0", q, 0);
    adv(1); lit("c_q1", q, 1);
    stop = 1; #1;
    lit("c_stop_tick", tick, 0); lit("c_stop_t", t, 0);
    adv(1); stop = 0; #1;
    lit("c_busy", busy, 0); lit("c_no_done", done, 0); lit("c_hold", q, 1);
    adv(1); lit("c_no_done2", done, 0);
    // en gating, free-run up, limit 2
    start = 1; up = 1; mode = 1; limit = 2;
    adv(1); start = 0;
    adv(1);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      #1;
      if (tick) ticks++;
      if (!en) lit("d_gated_tick", tick, 0);
      adv(1);
    end
    lit("d_ticks", ticks, 2); lit("d_q", q, 0);
    en = 1;
    stop = 1; adv(1); stop = 0;
    // start and stop together in IDLE
    start = 1; stop = 1;
    adv(1); start = 0; stop = 0; #1;
    lit("e_busy", busy, 0);
    // reset mid-run
    start = 1; up = 1; mode = 1; limit = 7;
    adv(1); start = 0;
    adv(3); lit("f_pre_q", q, 2);
    reset = 1;
    adv(1); lit("f_q", q, 0); lit("f_busy", busy, 0); lit("f_t", t, 0);
    adv(1); reset = 0; #1;
    lit("f_rel_t", t, 0); lit("f_rel_busy", busy, 0); lit("f_rel_q", q, 0);
    // limit 0 free-run ticks every enabled cycle
    start = 1; up = 1; mode = 1; limit = 0;
    adv(1); start = 0;
    adv(1);
    for (int i = 0; i < 5; i++) begin
      lit("g_tick", tick, 1); lit("g_q", q, 0);
      adv(1);
    end
    stop = 1; adv(1); stop = 0;
    // limit 0 one-shot down: DONE after one RUN cycle
    start = 1; up = 0; mode = 0; limit = 0;
    adv(1); start = 0;
    adv(1); lit("g1_tick", tick, 1);
    adv(1); lit("g1_done", done, 1);
    adv(1);
    // limit 15 down free-run wraps 15..0 back to 15
    start = 1; up = 0; mode = 1; limit = 15;
    adv(1); start = 0;
    adv(1);
    ticks = 0;
    for (int i = 0; i < 17; i++) begin
      lit("h_q", q, i < 16 ? 15 - i : 15);
      if (tick) ticks++;
      adv(1);
    end
    lit("h_ticks", ticks, 1);
    stop = 1; adv(1); stop = 0;
    adv(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
